timer_prescale_ctrl: RTL and testbench
======================================

Name: timer_prescale_ctrl

Overview:
- Synchronous prescale controller for the timer peripheral, clocked only by HCLK.
- Owns the active prescale select and generates a one-HCLK tick enable at the selected rate (HCLK/2^PRE).
- Requested prescale changes are applied only at a period boundary, so the timer never sees a truncated period.
- pre_active also drives any legacy divided-clock consumers as their PRE select, so both stay consistent.

Parameters:
- PRE_W, 3, width of the prescale select.
- CNT_W, 7, width of the period counter; must equal 2^PRE_W - 1.

Ports:
- HCLK  input  1  system clock.
- n_RST  input  1  reset; asynchronous, active-low.
- en  input  1  prescaler run enable, level.
- pre_wr  input  1  one-cycle write strobe for a new prescale select.
- pre_wdata  input  PRE_W  requested prescale select; 0 means /1, 7 means /128.
- cnt_clr  input  1  synchronous restart of the current period.
- pre_active  output  PRE_W  prescale select currently in force.
- tim_tick  output  1  one-HCLK enable pulse, once per prescaled period.
- pend  output  1  a requested change is waiting for the boundary.

Behaviour:
- Reset, asynchronous on n_RST low, including mid-operation:
  - state=STOP, cnt=0, pre_active=0, pre_pend=0, pend=0.
  - tim_tick=0 while n_RST is low.
- mask = (1<<pre_active)-1, zero-extended to CNT_W. hit = ((cnt & mask) == mask).
- tim_tick = en && state!=STOP && !cnt_clr && hit. Combinational from registers and inputs only; no further latency.
- States: STOP, RUN, PEND. pend = (state==PEND).
- STOP:
  - cnt held at 0.
  - pre_wr sets pre_active <= pre_wdata on the next edge; no boundary wait.
  - en=1 -> RUN.
- RUN:
  - cnt <= cnt+1 every cycle, wrapping at 2^CNT_W.
  - First tick lands on the 2^pre_active-th RUN cycle, then every 2^pre_active cycles.
  - PRE=0 ticks every cycle.
  - pre_wr with pre_wdata != pre_active: pre_pend <= pre_wdata, -> PEND.
  - pre_wr with pre_wdata == pre_active is ignored.
  - A write on a tick cycle is not applied on that tick; it waits for the next boundary.
- PEND:
  - cnt keeps counting; ticks continue at the old rate.
  - On a cycle with tim_tick=1: pre_active <= pre_pend, cnt <= 0. The new rate's first tick is 2^new cycles later.
  - pre_wr in PEND overwrites pre_pend; last write wins.
  - pre_wr on the boundary cycle:
    - Applied value is the old pre_pend.
    - The new write becomes the next pending value; stay in PEND, unless it equals the applied value, in which case -> RUN.
  - Otherwise a boundary returns to RUN.
- cnt_clr in RUN/PEND: cnt <= 0, no tick that cycle, pending request retained. cnt_clr in STOP: no effect.
- en=0 in RUN/PEND:
  - tim_tick forced 0 immediately; -> STOP, cnt <= 0.
  - A pending value is applied at once (pre_active <= pre_pend).
  - pre_wr in that same cycle wins over pre_pend.
- Simultaneous cnt_clr and boundary: cnt_clr suppresses the tick, so no switch occurs that cycle.
- Counter wrap: for pre_active=7, the tick lands at cnt=127, then cnt wraps to 0; no extra tick.

Decomposition:
- Shared timer package holds:
  - the state enum {STOP, RUN, PEND};
  - PRE_W and CNT_W localparams;
  - the prescale encoding constants PRE_DIV1 .. PRE_DIV128.
- One natural sub-module: prescale_match. Combinational mask generation and the hit compare from cnt and pre_active; reusable by the timer compare logic.

Test Plan:
- Reset release, en=1, PRE stays 0 -> tim_tick high on every cycle from the first RUN cycle; pre_active=0, pend=0.
- STOP, pre_wr with 3, then en=1 -> pre_active=3 the next cycle; ticks on RUN cycles 8, 16, 24; exactly one HCLK wide.
- RUN at PRE=2, pre_wr 5 at RUN cycle 2 -> pend=1; old tick at cycle 4 performs the switch, pre_active=5, pend=0; next ticks at cycles 36, 68.
- PEND with pre_wr 4 then pre_wr 6 before the boundary -> pre_active becomes 6 at the boundary; 4 is never applied.
- PRE=7, 300 RUN cycles -> ticks at 128 and 256 only; cnt wraps cleanly. cnt_clr at cycle 100 moves the next tick to cycle 228.
- Clean abort: PEND to 1, en dropped mid-period -> tim_tick 0 at once, pre_active=1, state STOP.
- Reset abort: n_RST pulsed low mid-period -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/timer_prescale_ctrl_pkg.sv
// Shared timer definitions: widths, FSM states and prescale select encodings.
package timer_prescale_ctrl_pkg;

  localparam int unsigned PRE_W = 3;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] PRE_DIV1   = 3'd0;
  localparam logic [PRE_W-1:0] PRE_DIV2   = 3'd1;
  localparam logic [PRE_W-1:0] PRE_DIV4   = 3'd2;
  localparam logic [PRE_W-1:0] PRE_DIV8   = 3'd3;
  localparam logic [PRE_W-1:0] PRE_DIV16  = 3'd4;
  localparam logic [PRE_W-1:0] PRE_DIV32  = 3'd5;
  localparam logic [PRE_W-1:0] PRE_DIV64  = 3'd6;
  localparam logic [PRE_W-1:0] PRE_DIV128 = 3'd7;

endpackage

// File: rtl/timer_prescale_ctrl_prescale_match.sv
// Period-end detect: low pre bits of the counter all ones.
module timer_prescale_ctrl_prescale_match #(
  parameter int unsigned PRE_W = 3,
  parameter int unsigned CNT_W = 7
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [PRE_W-1:0] pre,
  output logic             hit_c
);

  logic [CNT_W-1:0] mask;

  // Thermometer mask of width pre, then compare the masked counter to it.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(CNT_W); i++) begin
      mask[i] = (i < int'(pre));
    end
    hit_c = ((cnt & mask) == mask);
  end

endmodule

// File: rtl/timer_prescale_ctrl.sv
// Timer prescale controller: tick generation and boundary-aligned select changes.
module timer_prescale_ctrl #(
  parameter int unsigned PRE_W = timer_prescale_ctrl_pkg::PRE_W,
  parameter int unsigned CNT_W = timer_prescale_ctrl_pkg::CNT_W
) (
  input  logic             HCLK,
  input  logic             n_RST,
  input  logic             en,
  input  logic             pre_wr,
  input  logic [PRE_W-1:0] pre_wdata,
  input  logic             cnt_clr,
  output logic [PRE_W-1:0] pre_active,
  output logic             tim_tick,
  output logic             pend
);

  import timer_prescale_ctrl_pkg::*;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PRE_W-1:0] pre_active_n;
  logic [PRE_W-1:0] pre_pend, pre_pend_n;
  logic             hit_c;
  logic             tick_c;

  timer_prescale_ctrl_prescale_match #(
    .PRE_W (PRE_W),
    .CNT_W (CNT_W)
  ) u_match (
    .cnt   (cnt),
    .pre   (pre_active),
    .hit_c (hit_c)
  );

  assign tick_c   = en && (state != STOP) && !cnt_clr && hit_c;
  assign tim_tick = tick_c;
  assign pend     = (state == PEND);

  // State, counter and select registers.
  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) begin
      state      <= STOP;
      cnt        <= '0;
      pre_active <= '0;
      pre_pend   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pre_active <= pre_active_n;
      pre_pend   <= pre_pend_n;
    end
  end

  // Next-state: counting, pending capture and boundary application.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pre_active_n = pre_active;
    pre_pend_n   = pre_pend;
    case (state)
      STOP: begin
        cnt_n = '0;
        if (pre_wr) pre_active_n = pre_wdata;
        if (en)     state_n      = RUN;
      end
      RUN, PEND: begin
        if (!en) begin
          // Abort: flush any pending select, a same-cycle write wins.
          state_n = STOP;
          cnt_n   = '0;
          if (state == PEND) pre_active_n = pre_pend;
          if (pre_wr)        pre_active_n = pre_wdata;
        end else if ((state == PEND) && tick_c) begin
          // Boundary: apply old pending value; a same-cycle write re-arms.
          pre_active_n = pre_pend;
          cnt_n        = '0;
          if (pre_wr && (pre_wdata != pre_pend)) begin
            pre_pend_n = pre_wdata;
          end else begin
            state_n = RUN;
          end
        end else begin
          cnt_n = cnt_clr ? '0 : cnt + CNT_W'(1);
          if (state == PEND) begin
            if (pre_wr) pre_pend_n = pre_wdata;
          end else if (pre_wr && (pre_wdata != pre_active)) begin
            pre_pend_n = pre_wdata;
            state_n    = PEND;
          end
        end
      end
      default: begin
        state_n = STOP;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_prescale_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a period model.
module tb_timer_prescale_ctrl;

  logic       HCLK;
  logic       n_RST;
  logic       en;
  logic       pre_wr;
  logic [2:0] pre_wdata;
  logic       cnt_clr;
  logic [2:0] pre_active;
  logic       tim_tick;
  logic       pend;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, active/pending select, cycles into current period.
  int m_run, m_pre, m_pend, m_pp, m_age;
  int last_tick;
  int q[$];
  int seen4;

  timer_prescale_ctrl dut (
    .HCLK       (HCLK),
    .n_RST      (n_RST),
    .en         (en),
    .pre_wr     (pre_wr),
    .pre_wdata  (pre_wdata),
    .cnt_clr    (cnt_clr),
    .pre_active (pre_active),
    .tim_tick   (tim_tick),
    .pend       (pend)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pre = 0; m_pend = 0; m_pp = 0; m_age = 0;
  endtask

  task automatic model_step(input int t);
    int wd;
    wd = int'(pre_wdata);
    if (m_run == 0) begin
      m_age = 0;
      if (pre_wr) m_pre = wd;
      if (en) m_run = 1;
    end else if (!en) begin
      m_run = 0;
      m_age = 0;
      if (m_pend != 0) m_pre = m_pp;
      if (pre_wr) m_pre = wd;
      m_pend = 0;
    end else if ((m_pend != 0) && (t != 0)) begin
      m_pre = m_pp;
      m_age = 0;
      if (pre_wr && (wd != m_pp)) m_pp = wd;
      else m_pend = 0;
    end else begin
      m_age = cnt_clr ? 0 : (m_age + 1) % 128;
      if (m_pend != 0) begin
        if (pre_wr) m_pp = wd;
      end else if (pre_wr && (wd != m_pre)) begin
        m_pend = 1;
        m_pp   = wd;
      end
    end
  endtask

  // One clock: check outputs against the model, advance the model, move to next negedge.
  task automatic cyc();
    int exp_tick;
    #1;
    exp_tick = (en && (m_run != 0) && !cnt_clr && (((m_age + 1) % (1 << m_pre)) == 0)) ? 1 : 0;
    chk("tick", 32'(tim_tick), exp_tick);
    chk("pre_active", 32'(pre_active), m_pre);
    chk("pend", 32'(pend), m_pend);
    last_tick = int'(tim_tick);
    model_step(exp_tick);
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic apply_reset();
    #3;
    n_RST = 1'b0;
    #1;
    chk("rst_tick", 32'(tim_tick), 0);
    chk("rst_pre", 32'(pre_active), 0);
    chk("rst_pend", 32'(pend), 0);
    model_reset();
    en = 1'b0; pre_wr = 1'b0; cnt_clr = 1'b0; pre_wdata = 3'd0;
    @(negedge HCLK);
    @(negedge HCLK);
    n_RST = 1'b1;
  endtask

  initial begin
    n_RST = 1'b0; en = 1'b0; pre_wr = 1'b0; pre_wdata = 3'd0; cnt_clr = 1'b0;
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    chk("init_tick", 32'(tim_tick), 0);
    chk("init_pre", 32'(pre_active), 0);
    chk("init_pend", 32'(pend), 0);
    n_RST = 1'b1;

    // PRE=0: tick every RUN cycle.
    en = 1'b1;
    cyc();
    q.delete();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (last_tick != 0) q.push_back(k);
    end
    chk("s1_ticks", q.size(), 10);
    en = 1'b0;
    cyc();

    // Write 3 in STOP, then run: ticks at 8, 16, 24.
    pre_wr = 1'b1; pre_wdata = 3'd3;
    cyc();
    pre_wr = 1'b0;
    chk("s2_pre", 32'(pre_active), 3);
    en = 1'b1;
    cyc();
    q.delete();
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (last_tick != 0) q.push_back(k);
    end
    chk("s2_nticks", q.size(), 3);
    if (q.size() == 3) begin
      chk("s2_t0", q[0], 8);
      chk("s2_t1", q[1], 16);
      chk("s2_t2", q[2], 24);
    end
    en = 1'b0;
    cyc();

    // PRE=2, write 5 at RUN cycle 2: switch at 4, then 36, 68.
    pre_wr = 1'b1; pre_wdata = 3'd2;
    cyc();
    pre_wr = 1'b0;
    en = 1'b1;
    cyc();
    q.delete();
    for (int k = 1; k <= 70; k++) begin
      pre_wr = (k == 2); pre_wdata = 3'd5;
      cyc();
      if (last_tick != 0) q.push_back(k);
      if (k == 2) chk("s3_pend", 32'(pend), 1);
    end
    pre_wr = 1'b0;
    chk("s3_nticks", q.size(), 3);
    if (q.size() == 3) begin
      chk("s3_t0", q[0], 4);
      chk("s3_t1", q[1], 36);
      chk("s3_t2", q[2], 68);
    end
    chk("s3_pre", 32'(pre_active), 5);

    // Two writes while pending: last one wins, 4 never applied.
    pre_wr = 1'b1; pre_wdata = 3'd4;
    cyc();
    pre_wdata = 3'd6;
    cyc();
    pre_wr = 1'b0;
    seen4 = 0;
    for (int i = 0; i < 64 && pend; i++) begin
      cyc();
      if (pre_active == 3'd4) seen4++;
    end
    chk("s4_pend_done", 32'(pend), 0);
    chk("s4_never4", seen4, 0);
    chk("s4_pre", 32'(pre_active), 6);
    en = 1'b0;
    cyc();

    // PRE=7: ticks at 128 and 256 over 300 cycles.
    pre_wr = 1'b1; pre_wdata = 3'd7;
    cyc();
    pre_wr = 1'b0;
    en = 1'b1;
    cyc();
    q.delete();
    for (int k = 1; k <= 300; k++) begin
      cyc();
      if (last_tick != 0) q.push_back(k);
    end
    chk("s5_nticks", q.size(), 2);
    if (q.size() == 2) begin
      chk("s5_t0", q[0], 128);
      chk("s5_t1", q[1], 256);
    end
    en = 1'b0;
    cyc();

    // cnt_clr at cycle 100 moves the first tick to 228.
    en = 1'b1;
    cyc();
    q.delete();
    for (int k = 1; k <= 240; k++) begin
      cnt_clr = (k == 100);
      cyc();
      if (last_tick != 0) q.push_back(k);
    end
    cnt_clr = 1'b0;
    chk("s5c_nticks", q.size(), 1);
    if (q.size() == 1) chk("s5c_t0", q[0], 228);
    en = 1'b0;
    cyc();

    // Abort while pending: pending value applied, tick killed at once.
    en = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) cyc();
    pre_wr = 1'b1; pre_wdata = 3'd1;
    cyc();
    pre_wr = 1'b0;
    chk("s6_pend", 32'(pend), 1);
    for (int k = 0; k < 5; k++) cyc();
    en = 1'b0;
    #1;
    chk("s6_tick_off", 32'(tim_tick), 0);
    cyc();
    chk("s6_pre", 32'(pre_active), 1);
    chk("s6_pend_clr", 32'(pend), 0);

    // Asynchronous reset mid-period.
    en = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) cyc();
    apply_reset();

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      en        = ($urandom % 16) != 0;
      pre_wr    = ($urandom % 8) == 0;
      pre_wdata = 3'($urandom_range(0, 7));
      cnt_clr   = ($urandom % 32) == 0;
      if (($urandom % 600) == 0) apply_reset();
      else cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
